// File: rtl/video_terminal_pkg.sv
// Shared types and helpers for the character-cell terminal engine.
package video_terminal_pkg;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_NEWLINE,
        S_SCROLL
    } vt_state_e;

    localparam logic [6:0] CHAR_CR    = 7'h0D;
    localparam logic [6:0] CHAR_SPACE = 7'h20;

    // Narrow stores fold lower case onto upper case before dropping bit 6.
    function automatic logic [6:0] fold_char(input logic [6:0] rd,
                                             input int         char_w);
        logic [6:0] f;
        f = rd;
        if (char_w < 7) f = {1'b0, rd[5] & ~rd[6], rd[4:0]};
        return f;
    endfunction

endpackage

// File: rtl/video_terminal_if.sv
// Keyboard handshake, clear request and raster read port of the terminal.
interface video_terminal_if #(
    parameter int COLS   = 40,
    parameter int ROWS   = 24,
    parameter int CHAR_W = 6
) ();
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [6:0]        rd;
    logic              da;
    logic              rda_n;
    logic              clr_btn;
    logic              busy;
    logic [CW-1:0]     rast_col;
    logic [RW-1:0]     rast_row;
    logic [CHAR_W-1:0] rast_char;
    logic              rast_cursor;

    modport master (
        output rd, da, clr_btn, rast_col, rast_row,
        input  rda_n, busy, rast_char, rast_cursor
    );

    modport slave (
        input  rd, da, clr_btn, rast_col, rast_row,
        output rda_n, busy, rast_char, rast_cursor
    );
endinterface

// File: rtl/video_terminal_core_screen_ram.sv
// Simple dual-port screen memory: one synchronous write port and one
// registered read port (read-during-write returns the old word).
module screen_ram #(
    parameter int DEPTH  = 960,
    parameter int DATA_W = 6,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/video_terminal_core.sv
// Terminal engine: cursor/scroll FSM, circular top-row pointer, handshake,
// cursor blink and a one-cycle raster read port into the screen RAM.
module video_terminal_core
    import video_terminal_pkg::*;
#(
    parameter int COLS      = 40,
    parameter int ROWS      = 24,
    parameter int CHAR_W    = 6,
    parameter int BLINK_DIV = 2**24,
    parameter int ADDR_W    = $clog2(COLS*ROWS)
) (
    input  logic             clk,
    input  logic             mr_n,
    video_terminal_if.slave  bus
);
    localparam int NCELL = COLS * ROWS;
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CHAR_W-1:0] SPACE_W = CHAR_W'(CHAR_SPACE);

    vt_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [RW-1:0]     top_q, top_d;
    logic [6:0]        ch_q, ch_d;
    logic              armed_q, armed_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              oor_q, oor_d;
    logic              cur_q, cur_d;

    logic              accept;
    logic              printable;
    logic              blink_wrap;
    logic [6:0]        folded;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CHAR_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr;
    logic [CHAR_W-1:0] ram_rdata;
    logic              rda_n;
    logic              busy;

    // Logical row is rotated by the top pointer; one conditional subtract.
    function automatic logic [ADDR_W-1:0] phys_addr(
        input logic [RW-1:0] lr,
        input logic [RW-1:0] top,
        input logic [CW-1:0] c
    );
        logic [RW:0] pr;
        pr = {1'b0, lr} + {1'b0, top};
        if (int'(pr) >= ROWS) pr = pr - (RW+1)'(ROWS);
        return ADDR_W'(int'(pr) * COLS + int'(c));
    endfunction

    assign accept    = (state_q == S_IDLE) && bus.da && armed_q && !bus.clr_btn;
    assign printable = (ch_q[6:5] != 2'b00);
    assign folded    = fold_char(ch_q, CHAR_W);
    assign armed_d   = !bus.da ? 1'b1 : (accept ? 1'b0 : armed_q);

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            ch_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            ch_q    <= ch_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        ch_d    = ch_q;
        unique case (state_q)
            S_CLEAR: begin
                if (cnt_q == ADDR_W'(NCELL-1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    top_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    ch_d    = bus.rd;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ch_q == CHAR_CR) begin
                    state_d = S_NEWLINE;
                end else if (printable) begin
                    if (col_q == CW'(COLS-1)) begin
                        state_d = S_NEWLINE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NEWLINE: begin
                col_d = '0;
                if (row_q < RW'(ROWS-1)) begin
                    row_d   = row_q + 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (cnt_q == '0) begin
                    top_d = (top_q == RW'(ROWS-1)) ? '0 : top_q + 1'b1;
                end
                if (cnt_q == ADDR_W'(COLS)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
        if (bus.clr_btn) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = phys_addr(row_q, top_q, col_q);
        wdata = SPACE_W;
        rda_n = 1'b1;
        busy  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = cnt_q;
            end
            S_WRITE: begin
                rda_n = 1'b0;
                we    = printable;
                wdata = CHAR_W'(folded);
            end
            S_SCROLL: begin
                // Cycle 0 only advances top; the old top row is then blanked.
                busy  = 1'b1;
                we    = (cnt_q != '0);
                waddr = phys_addr(RW'(ROWS-1), top_q, CW'(cnt_q - 1'b1));
            end
            default: ;
        endcase
    end

    assign blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV-1));
    assign blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    assign blink_d     = blink_q ^ blink_wrap;

    assign oor_d = (int'(bus.rast_col) >= COLS) || (int'(bus.rast_row) >= ROWS);
    assign raddr = oor_d ? '0 : phys_addr(bus.rast_row, top_q, bus.rast_col);
    assign cur_d = !oor_d && !busy && blink_q
                   && (bus.rast_col == col_q) && (bus.rast_row == row_q);

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            oor_q       <= 1'b0;
            cur_q       <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            oor_q       <= oor_d;
            cur_q       <= cur_d;
        end
    end

    screen_ram #(
        .DEPTH  (NCELL),
        .DATA_W (CHAR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (mr_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign bus.rda_n       = rda_n;
    assign bus.busy        = busy;
    assign bus.rast_char   = oor_q ? SPACE_W : ram_rdata;
    assign bus.rast_cursor = cur_q;
endmodule

// File: tb/tb_video_terminal_core.sv
// Randomized directed bench for video_terminal_core against a
// row-array screen model.
module tb_video_terminal_core;
    localparam int COLS   = 40;
    localparam int ROWS   = 24;
    localparam int CHAR_W = 6;
    localparam int BD     = 64;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);

    logic clk  = 1'b0;
    logic mr_n = 1'b0;
    always #5 clk = ~clk;

    video_terminal_if #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W)) bus ();

    video_terminal_core #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .BLINK_DIV(BD)
    ) dut (
        .clk  (clk),
        .mr_n (mr_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc;

    always @(posedge clk or negedge mr_n) begin
        if (!mr_n) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [CHAR_W-1:0] scr [ROWS][COLS];
    int mc, mr;

    function automatic logic [CHAR_W-1:0] enc(input logic [6:0] ch);
        logic [6:0] v;
        v = ch;
        if (v >= 7'h60) v = v - 7'h20;
        return v[CHAR_W-1:0];
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 6'h20;
        mc = 0;
        mr = 0;
    endfunction

    function automatic void m_newline();
        mc = 0;
        if (mr < ROWS-1) begin
            mr++;
        end else begin
            for (int r = 0; r < ROWS-1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 6'h20;
        end
    endfunction

    function automatic void m_put(input logic [6:0] ch);
        if (ch == 7'h0D) begin
            m_newline();
        end else if (ch >= 7'h20) begin
            scr[mr][mc] = enc(ch);
            if (mc == COLS-1) m_newline();
            else mc++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_cell(input int c, input int r,
                             output logic [CHAR_W-1:0] ch,
                             output logic cur, output int k);
        @(negedge clk);
        bus.rast_col = CW'(c);
        bus.rast_row = RW'(r);
        @(negedge clk);
        ch  = bus.rast_char;
        cur = bus.rast_cursor;
        k   = cyc;
    endtask

    task automatic sweep(input string tag);
        logic [CHAR_W-1:0] ch;
        logic cur;
        int k, pos;
        logic ph;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(c, r, ch, cur, k);
                chk($sformatf("%s_char_c%0d_r%0d", tag, c, r),
                    32'(ch), 32'(scr[r][c]));
                pos = (k - 1) % BD;
                ph  = (((k - 1) / BD) % 2) == 1;
                if (pos >= 2 && pos <= BD-3)
                    chk($sformatf("%s_cur_c%0d_r%0d", tag, c, r),
                        32'(cur), 32'(ph && c == mc && r == mr));
            end
        end
    endtask

    task automatic send(input logic [6:0] ch, output int lat);
        @(negedge clk);
        bus.rd = ch;
        bus.da = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rda_n && lat < 300);
        chk("ack_seen", 32'(bus.rda_n), 32'd0);
        bus.da = 1'b0;
        m_put(ch);
        @(negedge clk);
        chk("ack_1cyc", 32'(bus.rda_n), 32'd1);
    endtask

    function automatic logic [6:0] rand_char(input bit allow_cr);
        int p;
        p = int'($urandom_range(0, 99));
        if (allow_cr && p < 5) return 7'h0D;
        if (p < 8) return 7'($urandom_range(0, 12));
        return 7'($urandom_range(32'h20, 32'h7F));
    endfunction

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n), 32'(COLS*ROWS));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [CHAR_W-1:0] ch;
        logic cur;
        int k, lat, acks, n;

        bus.rd       = '0;
        bus.da       = 1'b0;
        bus.clr_btn  = 1'b0;
        bus.rast_col = '0;
        bus.rast_row = '0;
        repeat (3) @(negedge clk);
        chk("rst_rda_n", 32'(bus.rda_n), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_char", 32'(bus.rast_char), 32'd0);
        chk("rst_cursor", 32'(bus.rast_cursor), 32'd0);

        mr_n = 1'b1;
        wait_clear("reset_clear_len");
        m_clear();
        sweep("init");

        read_cell(COLS, 0, ch, cur, k);
        chk("oor_col_char", 32'(ch), 32'h20);
        chk("oor_col_cur", 32'(cur), 32'd0);
        read_cell(0, ROWS, ch, cur, k);
        chk("oor_row_char", 32'(ch), 32'h20);
        chk("oor_row_cur", 32'(cur), 32'd0);
        read_cell(63, 31, ch, cur, k);
        chk("oor_max_char", 32'(ch), 32'h20);

        send(7'h41, lat);
        chk("ack_lat_A", 32'(lat), 32'd1);
        send(7'h61, lat);
        chk("ack_lat_a", 32'(lat), 32'd1);
        read_cell(0, 0, ch, cur, k);
        chk("cell_A", 32'(ch), 32'h01);
        read_cell(1, 0, ch, cur, k);
        chk("cell_a_folded", 32'(ch), 32'h01);

        @(negedge clk);
        bus.rd = 7'h42;
        bus.da = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.rda_n) acks++;
        end
        chk("hold_da_acks", 32'(acks), 32'd1);
        bus.da = 1'b0;
        m_put(7'h42);
        read_cell(2, 0, ch, cur, k);
        chk("hold_cell", 32'(ch), 32'h02);
        read_cell(3, 0, ch, cur, k);
        chk("hold_no_dup", 32'(ch), 32'h20);
        send(7'h42, lat);
        chk("rearm_lat", 32'(lat), 32'd1);
        read_cell(3, 0, ch, cur, k);
        chk("rearm_cell", 32'(ch), 32'h02);

        for (int i = 0; i < 300; i++) send(rand_char(1'b1), lat);
        sweep("rand");

        @(negedge clk);
        bus.clr_btn = 1'b1;
        @(negedge clk);
        bus.clr_btn = 1'b0;
        wait_clear("btn_clear_len");
        m_clear();
        for (int i = 0; i < 41; i++) begin
            send(7'($urandom_range(32'h20, 32'h7F)), lat);
            chk("wrap_no_busy", 32'(bus.busy), 32'd0);
        end
        sweep("wrap41");

        while (!(mr == ROWS-1 && mc >= 5))
            send(rand_char(mr < ROWS-1), lat);
        send(7'h0D, lat);
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.busy) n++;
        end
        chk("scroll_busy_len", 32'(n), 32'(COLS+1));
        sweep("scroll");

        send(7'h0D, lat);
        repeat (10) @(negedge clk);
        chk("scroll2_busy", 32'(bus.busy), 32'd1);
        bus.clr_btn = 1'b1;
        @(negedge clk);
        bus.clr_btn = 1'b0;
        wait_clear("abort_clear_len");
        m_clear();
        sweep("abort");

        @(negedge clk);
        bus.rd      = 7'h43;
        bus.da      = 1'b1;
        bus.clr_btn = 1'b1;
        @(negedge clk);
        chk("clr_wins_no_ack", 32'(bus.rda_n), 32'd1);
        bus.clr_btn = 1'b0;
        acks = 0;
        n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
            if (!bus.rda_n) acks++;
        end
        chk("pend_clear_len", 32'(n), 32'(COLS*ROWS));
        chk("pend_no_ack", 32'(acks), 32'd0);
        lat = 0;
        while (bus.rda_n && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("pend_ack_lat", 32'(lat), 32'd1);
        bus.da = 1'b0;
        m_clear();
        m_put(7'h43);
        read_cell(0, 0, ch, cur, k);
        chk("pend_cell", 32'(ch), 32'h03);

        for (int i = 0; i < 20; i++) send(rand_char(1'b1), lat);
        @(negedge clk);
        bus.clr_btn = 1'b1;
        @(negedge clk);
        bus.clr_btn = 1'b0;
        repeat (100) @(negedge clk);
        mr_n = 1'b0;
        @(negedge clk);
        chk("mr_rda_n", 32'(bus.rda_n), 32'd1);
        chk("mr_busy", 32'(bus.busy), 32'd1);
        chk("mr_char", 32'(bus.rast_char), 32'd0);
        chk("mr_cursor", 32'(bus.rast_cursor), 32'd0);
        mr_n = 1'b1;
        wait_clear("mr_clear_len");
        m_clear();
        sweep("mr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_terminal_core.md
# video_terminal_core

Parametrised character-cell terminal engine, successor to the fixed 40×24 shift-register terminal. It accepts ASCII characters through the `da`/`rda_n` handshake and stores them in an internal dual-port screen RAM instead of recirculating shift registers. Cursor placement, carriage return, line wrap, hardware scroll (a circular top-row pointer) and clear-screen are handled by one FSM. A raster-side read port returns the character code and cursor flag for any (column, row), so a separate sync/dot generator drives the display.

## Interface
Parameters:
- `COLS`, 40, characters per row
- `ROWS`, 24, rows per screen
- `CHAR_W`, 6, stored code width; 6 = Apple-1 fold, 7 = full ASCII
- `BLINK_DIV`, 2**24, clk cycles per cursor blink half-period
- `ADDR_W`, $clog2(COLS*ROWS), derived, not overridden

Ports:
- `clk`  in  1  system clock
- `mr_n`  in  1  master reset; asynchronous, active-low
- `rd`  in  7  ASCII character from keyboard/PIA
- `da`  in  1  data available, level
- `rda_n`  out  1  acknowledge; one-cycle low pulse
- `clr_btn`  in  1  clear request, synchronous, level
- `busy`  out  1  high while clearing or scrolling
- `rast_col`  in  $clog2(COLS)  raster column
- `rast_row`  in  $clog2(ROWS)  raster row, logical (0 = top line shown)
- `rast_char`  out  CHAR_W  stored code at (rast_col, rast_row)
- `rast_cursor`  out  1  cell is the cursor and blink phase is on

## Operation
- FSM states: CLEAR, IDLE, WRITE, NEWLINE, SCROLL.
- CLEAR:
  - Writes the space code to all COLS*ROWS cells, one per cycle, in address order.
  - Then sets cursor (0,0) and top = 0, and goes to IDLE.
- Accept: in IDLE, with `da`=1, armed=1 and `clr_btn`=0, the FSM latches `rd`, clears armed and goes to WRITE.
  - armed is set by any cycle in which `da`=0, which prevents a held `da` from being accepted twice.
- WRITE (one cycle): `rda_n`=0 and the character is decoded.
  - 0x0D (CR): go to NEWLINE.
  - 0x20–0x7F: write the code to the cursor cell.
    - For CHAR_W=6, store rd[5:0] with 0x60–0x7F folded to 0x40–0x5F.
    - Then col++. If col was COLS-1, go to NEWLINE; otherwise go to IDLE.
  - Any other code: acknowledged and discarded, go to IDLE.
- NEWLINE (one cycle): col = 0.
  - If row < ROWS-1: row++, go to IDLE.
  - Otherwise go to SCROLL.
- SCROLL:
  - top = (top+1) mod ROWS.
  - Clear the physical row that was previously top (it is now the new bottom line) over COLS cycles.
  - Go to IDLE with the cursor at (0, ROWS-1).
- Physical address = ((logical_row + top) mod ROWS) * COLS + col. The modulo is done by conditional subtract, not a divider.
- `clr_btn`=1 in any state forces CLEAR next cycle and aborts any operation in progress. Cells already written stay written until CLEAR overwrites them.
- Blink: a counter toggles the blink phase every BLINK_DIV cycles. `rast_cursor` is never asserted when `busy`=1.

## Timing
- Reset values:
  - `rda_n`=1, `busy`=1, `rast_char`=0, `rast_cursor`=0.
  - Cursor (0,0), top=0, armed=0, blink phase=0.
  - State CLEAR: the screen is cleared after every reset, taking COLS*ROWS cycles.
- Acceptance and acknowledge:
  - Accept is sampled in cycle N.
  - `rda_n` is low for exactly cycle N+1.
  - The RAM write commits at the end of N+1.
  - A printable, non-wrapping character returns the FSM to IDLE at N+2.
- Busy duration:
  - Scroll: `busy`=1 for COLS+1 cycles.
  - Wrap: `busy` stays 0; the only cost is the extra NEWLINE cycle.
- `da` while not IDLE: ignored, no `rda_n`. The source holds `da` until acknowledged.
- `clr_btn` and an accept in the same cycle: clear wins, no `rda_n`, the character stays pending.
- Raster port:
  - Read latency is 1 cycle; `rast_char` and `rast_cursor` are aligned.
  - A read of a cell written in the same cycle returns the old data.
  - Out-of-range coordinates return the space code and cursor 0.
- `mr_n` asserted mid-operation: all state returns immediately to its reset values, and CLEAR restarts after release.

## Structure
- Package `video_terminal_pkg`:
  - state enum
  - constants `CHAR_CR`=7'h0D and `CHAR_SPACE`=7'h20
  - function `fold_char(rd, CHAR_W)`
- Sub-module `screen_ram`: simple dual-port memory, COLS*ROWS × CHAR_W, one synchronous write port and one registered read port, inferred as block RAM.
- The core holds the FSM, cursor/top registers, address arithmetic, handshake and blink counter.

## Test plan
- Reset, then wait 960 cycles (40×24 clear): `busy` 1→0; reading every cell returns 0x20; cursor flag set only at (0,0) while blink phase is 1.
- Send 'A' (0x41), then 'a' (0x61) with CHAR_W=6: cells (0,0)=0x01 and (1,0)=0x01; one `rda_n` pulse each, occurring on the cycle after acceptance.
- Hold `da` high for 10 cycles with 'B': exactly one acknowledge and one write; a second 'B' is accepted only after a `da`=0 cycle.
- Write 41 printable characters: character 41 lands at (0,1); the cursor ends at (1,1).
- Fill 24 lines, then send CR on row 23:
  - `busy` is high for 41 cycles.
  - Logical row 0 now shows the former row 1.
  - Row 23 is all spaces; the cursor is at (0,23).
- Assert `clr_btn` during a scroll: the scroll aborts and a full clear follows; assert `da` together with `clr_btn`: no `rda_n` until the clear completes.
